// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and helpers for the byte-wide data-memory
//                initiator (FSM state encoding, word geometry, byte select).
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Little-endian byte lane select: lane 0 is word[7:0].
    function automatic logic [7:0] word_byte(input logic [31:0] word,
                                             input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_master.sv
`default_nettype none
// ============================================================================
//  Module      : mem_byte_master
//  Description : Splits one 32-bit lw/sw from the MEM stage into four
//                little-endian byte beats on a req/ack byte memory port,
//                stalls the pipeline while busy and returns the load word.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_byte_master
    import cpu_pkg::*;
#(
    parameter int MEM_BYTES = 32,
    parameter int TIMEOUT   = 15
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         MemRead_i,
    input  logic                         MemWrite_i,
    input  logic [31:0]                  addr_i,
    input  logic [31:0]                  data_i,
    output logic                         stall_o,
    output logic [31:0]                  data_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [$clog2(MEM_BYTES)-1:0] mem_addr_o,
    output logic [7:0]                   mem_wdata_o,
    input  logic [7:0]                   mem_rdata_i,
    input  logic                         mem_ack_i
);

    localparam int         c_addr_w  = $clog2(MEM_BYTES);
    localparam logic [7:0] c_wait_max = 8'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [1:0]            r_beat_cnt;
    logic [7:0]            r_wait_cnt;
    logic [c_addr_w-1:0]   r_base;
    logic [31:0]           r_wdata;
    logic                  r_op_write;
    logic [23:0]           r_shadow;
    logic [31:0]           r_data_o;

    logic                  w_request;
    logic                  w_aligned;
    logic                  w_accept;
    logic                  w_beat_ack;
    logic [c_addr_w-1:0]   w_beat_ofs;

    // Upper address bits fall outside the memory and are dropped on purpose.
    logic                  w_unused;
    assign w_unused = &{1'b0, addr_i[31:c_addr_w]};

    assign w_request  = MemRead_i | MemWrite_i;
    assign w_aligned  = (addr_i[1:0] == 2'b00);
    assign w_beat_ack = (r_state == BEAT) && mem_ack_i;
    assign w_beat_ofs = {{(c_addr_w-2){1'b0}}, r_beat_cnt};

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; misaligned requests abort before any beat is issued.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_request) begin
                    if (w_aligned) begin
                        w_next_state = BEAT;
                        w_accept     = 1'b1;
                    end else begin
                        w_next_state = ERR;
                    end
                end
            end
            BEAT: begin
                if (mem_ack_i) begin
                    if (r_beat_cnt == 2'd3) begin
                        w_next_state = DONE;
                    end
                end else if (r_wait_cnt == c_wait_max) begin
                    w_next_state = ERR;
                end
            end
            DONE:    w_next_state = IDLE;
            ERR:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Request latch, beat/wait counters and load assembly. The final load
    // byte is merged straight into data_o so it never exposes a partial word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_beat_cnt <= 2'd0;
            r_wait_cnt <= 8'd0;
            r_base     <= '0;
            r_wdata    <= 32'd0;
            r_op_write <= 1'b0;
            r_shadow   <= 24'd0;
            r_data_o   <= 32'd0;
        end else if (w_accept) begin
            r_base     <= addr_i[c_addr_w-1:0];
            r_wdata    <= data_i;
            r_op_write <= MemWrite_i;
            r_beat_cnt <= 2'd0;
            r_wait_cnt <= 8'd0;
        end else if (r_state == BEAT) begin
            if (w_beat_ack) begin
                r_wait_cnt <= 8'd0;
                r_beat_cnt <= r_beat_cnt + 2'd1;
                if (!r_op_write) begin
                    case (r_beat_cnt)
                        2'd0:    r_shadow[7:0]   <= mem_rdata_i;
                        2'd1:    r_shadow[15:8]  <= mem_rdata_i;
                        2'd2:    r_shadow[23:16] <= mem_rdata_i;
                        default: r_data_o        <= {mem_rdata_i, r_shadow};
                    endcase
                end
            end else begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end else begin
            r_beat_cnt <= 2'd0;
            r_wait_cnt <= 8'd0;
        end
    end

    // Port drive: beat signals are live only in BEAT, everything else idles at 0.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 8'd0;
        if (r_state == BEAT) begin
            mem_req_o   = 1'b1;
            mem_we_o    = r_op_write;
            mem_addr_o  = r_base + w_beat_ofs;
            mem_wdata_o = word_byte(r_wdata, r_beat_cnt);
        end
    end

    assign stall_o = (r_state == BEAT) ||
                     ((r_state == IDLE) && w_request && w_aligned);
    assign done_o  = (r_state == DONE);
    assign err_o   = (r_state == ERR);
    assign data_o  = r_data_o;

endmodule
`default_nettype wire

// File: tb/tb_mem_byte_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_byte_master
//  Description : Self-checking bench for mem_byte_master with a byte memory
//                responder and an array-based reference of memory contents.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_byte_master;

    localparam int MB = 32;
    localparam int TO = 15;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] addr_i, data_i;
    logic        stall_o, done_o, err_o;
    logic [31:0] data_o;
    logic        mem_req_o, mem_we_o;
    logic [4:0]  mem_addr_o;
    logic [7:0]  mem_wdata_o, mem_rdata_i;
    logic        mem_ack_i;

    always #5 clk_i = ~clk_i;

    mem_byte_master #(.MEM_BYTES(MB), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .data_i(data_i),
        .stall_o(stall_o), .data_o(data_o), .done_o(done_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { bit we; int addr; logic [7:0] wd; } beat_t;
    beat_t      beat_q[$];
    logic [7:0] resp_mem [MB];
    logic [7:0] ref_mem  [MB];
    int         txn_start = 0;
    bit         ack_rand  = 1'b0;
    int         hold_beat = -1;
    int         hold_len  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte memory: answers beats on the falling edge, optionally with random
    // or forced ack gaps; acks outside a request are random noise.
    initial begin : responder
        int misses;
        int hold_used;
        bit give;
        misses    = 0;
        hold_used = 0;
        for (int i = 0; i < MB; i++) resp_mem[i] = 8'(i * 7 + 3);
        mem_ack_i   = 1'b0;
        mem_rdata_i = 8'd0;
        forever begin
            @(negedge clk_i);
            if (mem_req_o === 1'b1) begin
                give = 1'b1;
                if (ack_rand && misses < 4 && $urandom_range(2) == 0) give = 1'b0;
                if ((beat_q.size() - txn_start) == hold_beat && hold_used < hold_len) begin
                    give = 1'b0;
                    hold_used++;
                end
                if (give) begin
                    misses      = 0;
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = resp_mem[mem_addr_o];
                    if (mem_we_o) resp_mem[mem_addr_o] = mem_wdata_o;
                    beat_q.push_back('{we: mem_we_o, addr: int'(mem_addr_o), wd: mem_wdata_o});
                end else begin
                    misses++;
                    mem_ack_i   = 1'b0;
                    mem_rdata_i = 8'($urandom);
                end
            end else begin
                hold_used   = 0;
                mem_ack_i   = 1'($urandom_range(1));
                mem_rdata_i = 8'($urandom);
            end
        end
    end

    function automatic logic [31:0] ref_load(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[(int'(a[4:0]) + i) % MB];
        return w;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) ref_mem[(int'(a[4:0]) + i) % MB] = d[8*i +: 8];
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < MB; i++) chk(tag, {24'd0, resp_mem[i]}, {24'd0, ref_mem[i]});
    endtask

    task automatic check_beats(input logic [31:0] a, input bit wr, input logic [31:0] d, input int n);
        chk("beat_count", beat_q.size() - txn_start, n);
        for (int i = 0; i < n && txn_start + i < beat_q.size(); i++) begin
            chk("beat_addr", beat_q[txn_start + i].addr, (int'(a[4:0]) + i) % MB);
            chk("beat_we", {31'd0, beat_q[txn_start + i].we}, {31'd0, wr});
            if (wr) chk("beat_wdata", {24'd0, beat_q[txn_start + i].wd}, {24'd0, d[8*i +: 8]});
        end
    endtask

    // One CPU access from IDLE; reports how many cycles after acceptance the
    // done/err pulse appeared and checks stall/data_o behaviour on the way.
    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output bit got_done, output bit got_err, output int ncyc);
        logic [31:0] old;
        bit          aligned;
        bit          fin;
        aligned = (a[1:0] == 2'b00);
        @(posedge clk_i); #1;
        MemWrite_i = wr;
        MemRead_i  = !wr;
        addr_i     = a;
        data_i     = d;
        txn_start  = beat_q.size();
        old        = data_o;
        @(negedge clk_i);
        chk("stall_on_request", {31'd0, stall_o}, {31'd0, aligned});
        chk("no_req_in_idle", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk_i); #1;
        MemWrite_i = 1'b0;
        MemRead_i  = 1'b0;
        addr_i     = $urandom;
        data_i     = $urandom;
        got_done = 1'b0; got_err = 1'b0; fin = 1'b0; ncyc = 0;
        for (int k = 1; k <= 100 && !fin; k++) begin
            @(negedge clk_i);
            if (done_o || err_o) begin
                fin = 1'b1; ncyc = k; got_done = done_o; got_err = err_o;
            end else begin
                chk("stall_busy", {31'd0, stall_o}, 32'd1);
                chk("data_hold_busy", data_o, old);
                @(posedge clk_i);
            end
        end
        chk("completion_bound", {31'd0, fin}, 32'd1);
        if (fin) begin
            chk("stall_at_end", {31'd0, stall_o}, 32'd0);
            chk("req_low_at_end", {31'd0, mem_req_o}, 32'd0);
            if (got_err || wr) chk("data_unchanged", data_o, old);
        end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("single_pulse", {30'd0, done_o, err_o}, 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit          gd, ge;
        int          nc;
        logic [31:0] a, d, dd;
        bit          wr;

        for (int i = 0; i < MB; i++) ref_mem[i] = 8'(i * 7 + 3);
        rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = 32'd0; data_i = 32'd0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_pulses", {30'd0, done_o, err_o}, 32'd0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_addr", {27'd0, mem_addr_o}, 32'd0);
        chk("rst_wdata", {24'd0, mem_wdata_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Aligned store, ack every cycle.
        access(1'b1, 32'h08, 32'hDEADBEEF, gd, ge, nc);
        chk("t1_done", {31'd0, gd}, 32'd1);
        chk("t1_latency", nc, 5);
        check_beats(32'h08, 1'b1, 32'hDEADBEEF, 4);
        ref_store(32'h08, 32'hDEADBEEF, 4);
        check_mem("t1_mem");

        // Load back the stored word.
        access(1'b0, 32'h08, 32'h0, gd, ge, nc);
        chk("t2_done", {31'd0, gd}, 32'd1);
        chk("t2_latency", nc, 5);
        chk("t2_data", data_o, 32'hDEADBEEF);
        chk("t2_data_ref", data_o, ref_load(32'h08));
        check_beats(32'h08, 1'b0, 32'h0, 4);

        // Misaligned load.
        access(1'b0, 32'h06, 32'h0, gd, ge, nc);
        chk("t3_err", {31'd0, ge}, 32'd1);
        chk("t3_latency", nc, 1);
        chk("t3_no_beats", beat_q.size() - txn_start, 0);

        // Store with ack withheld on beat 2: timeout abort, two bytes landed.
        hold_beat = 2; hold_len = 20;
        access(1'b1, 32'h10, 32'h12345678, gd, ge, nc);
        chk("t4_err", {31'd0, ge}, 32'd1);
        chk("t4_latency", nc, 2 + TO + 1);
        check_beats(32'h10, 1'b1, 32'h12345678, 2);
        ref_store(32'h10, 32'h12345678, 2);
        check_mem("t4_mem");
        hold_beat = -1; hold_len = 0;
        chk("t4_data_kept", data_o, 32'hDEADBEEF);

        // Top-of-memory store and aliasing of high address bits.
        access(1'b1, 32'h1C, 32'hCAFEF00D, gd, ge, nc);
        chk("t5_done", {31'd0, gd}, 32'd1);
        check_beats(32'h1C, 1'b1, 32'hCAFEF00D, 4);
        ref_store(32'h1C, 32'hCAFEF00D, 4);
        access(1'b1, 32'h3C, 32'h0BADC0DE, gd, ge, nc);
        chk("t5_alias_done", {31'd0, gd}, 32'd1);
        for (int i = 0; i < 4 && txn_start + i < beat_q.size(); i++)
            chk("t5_alias_addr", beat_q[txn_start + i].addr, 28 + i);
        ref_store(32'h3C, 32'h0BADC0DE, 4);
        check_mem("t5_mem");

        // Reset during beat 1 of a store.
        dd = 32'hA1B2C3D4;
        @(posedge clk_i); #1;
        MemWrite_i = 1'b1; addr_i = 32'h04; data_i = dd; txn_start = beat_q.size();
        @(posedge clk_i); #1;
        MemWrite_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("t6_in_beat1", {27'd0, mem_addr_o}, 32'd5);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("t6_stall", {31'd0, stall_o}, 32'd0);
        chk("t6_req", {31'd0, mem_req_o}, 32'd0);
        chk("t6_we", {31'd0, mem_we_o}, 32'd0);
        chk("t6_addr", {27'd0, mem_addr_o}, 32'd0);
        chk("t6_wdata", {24'd0, mem_wdata_o}, 32'd0);
        chk("t6_pulses", {30'd0, done_o, err_o}, 32'd0);
        chk("t6_data", data_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("t6_no_pulse", {30'd0, done_o, err_o}, 32'd0);
        check_beats(32'h04, 1'b1, dd, 2);
        ref_store(32'h04, dd, 2);
        check_mem("t6_mem");
        access(1'b0, 32'h04, 32'h0, gd, ge, nc);
        chk("t6_lw_done", {31'd0, gd}, 32'd1);
        chk("t6_lw_latency", nc, 5);
        chk("t6_lw_data", data_o, ref_load(32'h04));

        // Randomized traffic with random ack gaps.
        ack_rand = 1'b1;
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom_range(1));
            a  = $urandom;
            if ($urandom_range(4) != 0) a[1:0] = 2'b00;
            d  = $urandom;
            access(wr, a, d, gd, ge, nc);
            if (a[1:0] == 2'b00) begin
                chk("rnd_done", {31'd0, gd}, 32'd1);
                chk("rnd_latency_min", {31'd0, (nc >= 5)}, 32'd1);
                check_beats(a, wr, d, 4);
                if (wr) ref_store(a, d, 4);
                else    chk("rnd_load", data_o, ref_load(a));
            end else begin
                chk("rnd_err", {31'd0, ge}, 32'd1);
                chk("rnd_err_latency", nc, 1);
                chk("rnd_no_beats", beat_q.size() - txn_start, 0);
            end
        end
        ack_rand = 1'b0;
        check_mem("rnd_mem");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
